// File: rtl/spi_master_ctrl_pkg.sv
// =============================================================================
// spi_master_ctrl_pkg : shared constants and state encoding for the SPI master
// Rev 1.0
// =============================================================================
`default_nettype none

package spi_master_ctrl_pkg;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        SPIM_IDLE  = 3'd0,
        SPIM_SETUP = 3'd1,
        SPIM_XFER  = 3'd2,
        SPIM_HOLD  = 3'd3,
        SPIM_DONE  = 3'd4
    } spim_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_master_ctrl_sclk_gen.sv
// =============================================================================
// spi_sclk_gen : SCLK divider producing leading/trailing edge strobes per frame
// Rev 1.0
// =============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int FRAME_WIDTH = 16,
    parameter int CLK_DIV     = 4,
    parameter int CPOL        = 0
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam int   DIVW     = $clog2(CLK_DIV);
    localparam int   EDGES    = 2 * FRAME_WIDTH;
    localparam int   EW       = $clog2(EDGES + 1);
    localparam logic IDLE_LVL = 1'(CPOL);

    logic [DIVW-1:0] div_cnt_q, div_cnt_d;
    logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
    logic            sclk_q, sclk_d;
    logic            w_tick;

    // Strobes are asserted in the cycle whose closing edge toggles sclk_q.
    assign w_tick    = enable && (div_cnt_q == DIVW'(CLK_DIV - 1));
    assign lead_stb  = w_tick && !edge_cnt_q[0];
    assign trail_stb = w_tick && edge_cnt_q[0];
    assign last_edge = w_tick && (edge_cnt_q == EW'(EDGES - 1));
    assign sclk      = sclk_q;

    always_comb begin
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        if (!enable) begin
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            sclk_d     = IDLE_LVL;
        end else if (w_tick) begin
            div_cnt_d  = '0;
            edge_cnt_d = edge_cnt_q + EW'(1);
            sclk_d     = ~sclk_q;
        end else begin
            div_cnt_d  = div_cnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= IDLE_LVL;
        end else begin
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// =============================================================================
// spi_master_ctrl : parametrised SPI master with CPOL/CPHA, multi-CS, handshake
// Rev 1.0
// =============================================================================
`default_nettype none

module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int FRAME_WIDTH = 16,
    parameter int CLK_DIV     = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int NUM_CS      = 1,
    parameter int CSW         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    input  logic [CSW-1:0]         cs_sel,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [NUM_CS-1:0]      cs_n
);

    localparam int CNTW            = $clog2(CLK_DIV);
    localparam bit SAMPLE_ON_TRAIL = (CPHA != 0);

    spim_state_e            state_q, state_d;
    logic [CNTW-1:0]        phase_cnt_q, phase_cnt_d;
    logic [FRAME_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [NUM_CS-1:0]      cs_n_q, cs_n_d;
    logic                   mosi_q, mosi_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;

    logic [NUM_CS-1:0]      w_cs_dec;
    logic                   w_lead, w_trail, w_last;
    logic                   w_sample, w_shift;
    logic                   w_phase_end;

    spi_sclk_gen #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .CLK_DIV     (CLK_DIV),
        .CPOL        (CPOL)
    ) u_sclk_gen (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .enable    (state_q == SPIM_XFER),
        .sclk      (sclk),
        .lead_stb  (w_lead),
        .trail_stb (w_trail),
        .last_edge (w_last)
    );

    // Out-of-range selects decode to no asserted line; the frame still runs.
    always_comb begin
        w_cs_dec = {NUM_CS{CS_DEASSERT}};
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) w_cs_dec[i] = CS_ASSERT;
        end
    end

    // CPHA=0 never shifts after the final trailing edge so the last bit holds.
    assign w_sample    = SAMPLE_ON_TRAIL ? w_trail : w_lead;
    assign w_shift     = SAMPLE_ON_TRAIL ? w_lead : (w_trail && !w_last);
    assign w_phase_end = (phase_cnt_q == CNTW'(CLK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rx_valid_d  = 1'b0;
        case (state_q)
            SPIM_IDLE: begin
                if (tx_valid) begin
                    state_d     = SPIM_SETUP;
                    phase_cnt_d = '0;
                    tx_sr_d     = tx_data;
                    rx_sr_d     = '0;
                    cs_n_d      = w_cs_dec;
                    mosi_d      = SAMPLE_ON_TRAIL ? 1'b0 : tx_data[FRAME_WIDTH-1];
                end
            end
            SPIM_SETUP: begin
                if (w_phase_end) begin
                    state_d     = SPIM_XFER;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt_q + CNTW'(1);
                end
            end
            SPIM_XFER: begin
                if (w_sample) rx_sr_d = {rx_sr_q[FRAME_WIDTH-2:0], miso};
                if (w_shift) begin
                    mosi_d  = SAMPLE_ON_TRAIL ? tx_sr_q[FRAME_WIDTH-1] : tx_sr_q[FRAME_WIDTH-2];
                    tx_sr_d = tx_sr_q << 1;
                end
                if (w_last) state_d = SPIM_HOLD;
            end
            SPIM_HOLD: begin
                if (w_phase_end) begin
                    state_d     = SPIM_DONE;
                    phase_cnt_d = '0;
                    cs_n_d      = {NUM_CS{CS_DEASSERT}};
                    mosi_d      = 1'b0;
                    rx_valid_d  = 1'b1;
                    rx_data_d   = rx_sr_q;
                end else begin
                    phase_cnt_d = phase_cnt_q + CNTW'(1);
                end
            end
            SPIM_DONE: state_d = SPIM_IDLE;
            default:   state_d = SPIM_IDLE;
        endcase
        tx_ready_d = (state_d == SPIM_IDLE);
        busy_d     = (state_d != SPIM_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SPIM_IDLE;
            phase_cnt_q <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            cs_n_q      <= {NUM_CS{CS_DEASSERT}};
            mosi_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

`default_nettype wire
